// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and load/store (D).
// Data wins ties, but a fetch is forced through after MAX_DATA_STREAK data grants.
module unified_mem_arbiter #(
   parameter int DBITS           = 32,
   parameter int ABITS           = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_req,
   input  logic [ABITS-1:0] i_addr,
   input  logic             i_kill,
   output logic             i_ack,
   output logic [DBITS-1:0] i_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [ABITS-1:0] d_addr,
   input  logic [DBITS-1:0] d_wdata,
   output logic             d_ack,
   output logic [DBITS-1:0] d_rdata,
   output logic             m_req,
   output logic             m_we,
   output logic [ABITS-1:0] m_addr,
   output logic [DBITS-1:0] m_wdata,
   input  logic             m_ack,
   input  logic [DBITS-1:0] m_rdata,
   output logic             busy
);

   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {IDLE, ISSUE_I, ISSUE_D, RESP} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

   state_t        state, state_nxt;
   owner_t        owner;
   logic [SW-1:0] streak;
   logic          kill_pend;
   logic          i_eff;
   logic          grant_i, grant_d;

   // Handshake: a requester holds req and its payload until the one-cycle ack;
   // the memory holds m_ack/m_rdata for one cycle while m_req is high.
   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      i_eff     = i_req & ~i_kill;
      case (state)
         IDLE: begin
            if (d_req && !(i_eff && streak == STREAK_MAX)) begin
               grant_d   = 1'b1;
               state_nxt = ISSUE_D;
            end else if (i_eff) begin
               grant_i   = 1'b1;
               state_nxt = ISSUE_I;
            end
         end
         ISSUE_I, ISSUE_D: begin
            if (m_ack) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= OWN_NONE;
         streak    <= '0;
         kill_pend <= 1'b0;
         m_we      <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         state <= state_nxt;
         if (grant_i) begin
            owner   <= OWN_I;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            streak  <= '0;
         end
         if (grant_d) begin
            owner   <= OWN_D;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            if (!i_eff)                    streak <= '0;
            else if (streak != STREAK_MAX) streak <= streak + 1'b1;
         end
         if (state == ISSUE_I && i_kill) kill_pend <= 1'b1;
         if (state == ISSUE_I && m_ack)  i_rdata   <= m_rdata;
         if (state == ISSUE_D && m_ack)  d_rdata   <= m_rdata;
         if (state == RESP) begin
            kill_pend <= 1'b0;
            owner     <= OWN_NONE;
         end
      end
   end

   // A kill raised during the issue or in the response cycle itself hides the fetch ack.
   assign m_req = (state == ISSUE_I) || (state == ISSUE_D);
   assign busy  = (state != IDLE);
   assign i_ack = (state == RESP) && (owner == OWN_I) && !kill_pend && !i_kill;
   assign d_ack = (state == RESP) && (owner == OWN_D);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: bench plays both requesters and the memory.
module tb_unified_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req, i_kill, i_ack;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_ack;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        m_req, m_we, m_ack;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        busy;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   unified_mem_arbiter #(.DBITS(32), .ABITS(32), .MAX_DATA_STREAK(4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mreq"},  m_req,   0);
      check({tag, "_mwe"},   m_we,    0);
      check({tag, "_maddr"}, m_addr,  0);
      check({tag, "_mwd"},   m_wdata, 0);
      check({tag, "_acks"},  {i_ack, d_ack}, 0);
      check({tag, "_busy"},  busy,    0);
      check({tag, "_irdat"}, i_rdata, 0);
      check({tag, "_drdat"}, d_rdata, 0);
   endtask

   // From IDLE with requests already driven: one access with m_ack in the first issue cycle.
   task automatic access(input string tag, input logic exp_i, input logic [31:0] exp_addr,
                         input logic [31:0] rd);
      step();
      check({tag, "_mreq"},  m_req, 1);
      check({tag, "_maddr"}, m_addr, exp_addr);
      m_ack   = 1'b1;
      m_rdata = rd;
      step();
      check({tag, "_ack"}, {i_ack, d_ack}, exp_i ? 2'b10 : 2'b01);
      check({tag, "_rdata"}, exp_i ? i_rdata : d_rdata, rd);
      m_ack = 1'b0;
      step();
   endtask

   initial begin
      logic grant_is_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      reset = 1'b0;
      i_req = 0; i_addr = 0; i_kill = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      m_ack = 0; m_rdata = 0;
      step();
      step();
      check_all_zero("reset");
      reset = 1'b1;

      // I-only fetch, single-cycle memory
      i_req = 1; i_addr = 32'h100;
      check("t1_idle_busy", busy, 0);
      step();
      check("t1_mreq", m_req, 1);
      check("t1_mwe", m_we, 0);
      check("t1_maddr", m_addr, 32'h100);
      check("t1_busy_iss", busy, 1);
      m_ack = 1; m_rdata = 32'hDEADBEEF;
      step();
      check("t1_iack", i_ack, 1);
      check("t1_irdata", i_rdata, 32'hDEADBEEF);
      check("t1_mreq_resp", m_req, 0);
      check("t1_busy_resp", busy, 1);
      m_ack = 0; i_req = 0;
      step();
      check("t1_iack_off", i_ack, 0);
      check("t1_busy_idle", busy, 0);

      // D store with 4-cycle memory latency
      d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678;
      step();
      for (int k = 0; k < 4; k++) begin
         check("t2_mreq", m_req, 1);
         check("t2_mwe", m_we, 1);
         check("t2_maddr", m_addr, 32'h200);
         check("t2_mwdata", m_wdata, 32'h12345678);
         check("t2_dack_early", d_ack, 0);
         if (k == 3) begin
            m_ack = 1; m_rdata = 32'hAAAA5555;
         end
         step();
      end
      check("t2_dack", d_ack, 1);
      check("t2_iack", i_ack, 0);
      check("t2_mreq_off", m_req, 0);
      m_ack = 0; d_req = 0; d_we = 0;
      step();
      check("t2_dack_off", d_ack, 0);
      check("t2_busy", busy, 0);

      // Both requesters continuously: D x4 then I, twice
      i_req = 1; i_addr = 32'h300;
      d_req = 1; d_addr = 32'h400;
      for (int g = 0; g < 10; g++)
         access($sformatf("t3_g%0d", g), grant_is_i[g], grant_is_i[g] ? 32'h300 : 32'h400,
                32'h1000 + 32'(g));

      // Kill during a 3-cycle fetch, with a D arriving behind it
      d_req = 0; i_addr = 32'h500;
      step();
      check("t4_maddr", m_addr, 32'h500);
      i_kill = 1; d_req = 1; d_addr = 32'h600;
      step();
      check("t4_mreq2", m_req, 1);
      i_kill = 0; i_req = 0;
      step();
      check("t4_mreq3", m_req, 1);
      m_ack = 1; m_rdata = 32'h77;
      step();
      check("t4_resp_acks", {i_ack, d_ack}, 2'b00);
      check("t4_resp_busy", busy, 1);
      m_ack = 0;
      step();
      check("t4_idle_busy", busy, 0);
      check("t4_idle_iack", i_ack, 0);
      access("t4_d", 1'b0, 32'h600, 32'h66);
      d_req = 0;

      // Raise streak to 4, then reset in the middle of the 4th D issue
      i_req = 1; i_addr = 32'h900;
      d_req = 1; d_addr = 32'hA00;
      for (int g = 0; g < 3; g++)
         access($sformatf("t5_pre%0d", g), 1'b0, 32'hA00, 32'h2000 + 32'(g));
      step();
      check("t5_iss_maddr", m_addr, 32'hA00);
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("t5_async");
      i_req = 0; d_req = 0;
      step();
      step();
      reset = 1'b1;
      i_req = 1; d_req = 1;
      access("t5_post_d", 1'b0, 32'hA00, 32'h3000);
      d_req = 0;
      access("t5_post_i", 1'b1, 32'h900, 32'h3001);
      i_req = 0;

      // m_ack glitches in IDLE and RESP; new requests arriving during RESP
      m_ack = 1;
      step();
      check("t6_idle_glitch_busy", busy, 0);
      check("t6_idle_glitch_acks", {i_ack, d_ack}, 2'b00);
      check("t6_idle_glitch_mreq", m_req, 0);
      m_ack = 0;
      i_req = 1; i_addr = 32'h800;
      step();
      m_ack = 1; m_rdata = 32'h55;
      step();
      check("t6_iack", i_ack, 1);
      d_req = 1; d_addr = 32'h700; d_we = 0;
      step();
      check("t6_after_resp_acks", {i_ack, d_ack}, 2'b00);
      check("t6_after_resp_busy", busy, 0);
      m_ack = 0;
      access("t6_d", 1'b0, 32'h700, 32'h99);
      i_req = 0; d_req = 0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
